// File: rtl/tape_reader.sv
// Punched-tape reader front end: buffers host tape codes in a FIFO and presents
// them one at a time on the four-phase rdy/ack input handshake of the I/O unit.
module tape_reader #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = 4,
  parameter int unsigned CHAR_GAP   = 8,
  parameter bit          SKIP_BLANK = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic [4:0]    host_data,
  input  logic          enable,
  input  logic          flush,
  output logic          input_rdy_to_dev_side,
  input  logic          input_ack_from_io,
  output logic [4:0]    input_data_to_io,
  output logic [AW:0]   fifo_count,
  output logic          busy,
  output logic [15:0]   chars_read
);

  localparam int unsigned DW = 5;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RDY     = 2'd1,
    RELEASE = 2'd2,
    GAP     = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [DW-1:0]   data_q, data_d;
  logic            rdy_q, rdy_d;
  logic            busy_q, busy_d;
  logic            host_ready_q, host_ready_d;
  logic [15:0]     chars_q, chars_d;
  logic [GW-1:0]   gap_q, gap_d;

  logic            push_c;
  logic            pop_c;
  logic            empty_c;
  logic [DW-1:0]   head_c;

  // host_ready is the registered !full, so a same-cycle pop never opens the door early
  assign push_c  = host_valid && host_ready_q && !flush;
  assign empty_c = (count_q == '0);
  assign head_c  = mem_q[rd_ptr_q];

  // Fetch/handshake sequencing
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    chars_d = chars_q;
    gap_d   = gap_q;
    pop_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && !empty_c && !flush) begin
          pop_c = 1'b1;
          if (!(SKIP_BLANK && (head_c == '0))) begin
            data_d  = head_c;
            state_d = RDY;
          end
        end
      end
      RDY: begin
        if (rdy_q && input_ack_from_io) state_d = RELEASE;
      end
      RELEASE: begin
        if (!input_ack_from_io) begin
          chars_d = chars_q + 16'd1;
          if (CHAR_GAP == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            gap_d   = GW'(CHAR_GAP);
          end
        end
      end
      GAP: begin
        gap_d = gap_q - GW'(1);
        if (gap_q <= GW'(1)) begin
          state_d = IDLE;
          gap_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointers and occupancy; flush wins over push and pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // rdy rises one cycle after entering RDY and is held off while ack is still high
  always_comb begin
    rdy_d        = (state_q == RDY) && (state_d == RDY) && !input_ack_from_io;
    busy_d       = (state_d != IDLE);
    host_ready_d = (count_d != CW'(DEPTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_q       <= '0;
      rdy_q        <= 1'b0;
      busy_q       <= 1'b0;
      host_ready_q <= 1'b1;
      chars_q      <= '0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_q       <= data_d;
      rdy_q        <= rdy_d;
      busy_q       <= busy_d;
      host_ready_q <= host_ready_d;
      chars_q      <= chars_d;
      gap_q        <= gap_d;
    end
  end

  // Character storage carries no reset; occupancy alone defines validity
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= host_data;
  end

  assign host_ready            = host_ready_q;
  assign input_rdy_to_dev_side = rdy_q;
  assign input_data_to_io      = data_q;
  assign fifo_count            = count_q;
  assign busy                  = busy_q;
  assign chars_read            = chars_q;

endmodule

// File: tb/tb_tape_reader.sv
// Directed bench for tape_reader: handshake timing, blank skipping, full FIFO,
// long ack, flush during a character and asynchronous reset.
module tb_tape_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_valid;
  logic        host_ready;
  logic [4:0]  host_data;
  logic        enable;
  logic        flush;
  logic        rdy;
  logic        ack;
  logic [4:0]  data;
  logic [4:0]  fifo_count;
  logic        busy;
  logic [15:0] chars_read;

  int n_checks = 0;
  int n_fail   = 0;

  tape_reader #(.DEPTH(16), .AW(4), .CHAR_GAP(8), .SKIP_BLANK(1'b1)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .host_valid            (host_valid),
    .host_ready            (host_ready),
    .host_data             (host_data),
    .enable                (enable),
    .flush                 (flush),
    .input_rdy_to_dev_side (rdy),
    .input_ack_from_io     (ack),
    .input_data_to_io      (data),
    .fifo_count            (fifo_count),
    .busy                  (busy),
    .chars_read            (chars_read)
  );

  always #5 clk = ~clk;

  // Drive and sample 1 time unit after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] d);
    host_valid = 1'b1;
    host_data  = d;
    tick();
    host_valid = 1'b0;
  endtask

  // I/O unit model: ack one cycle after rdy, release one cycle after rdy falls
  task automatic io_handshake(output logic [4:0] d, output bit ok);
    int n;
    ok = 1'b1;
    d  = '0;
    n  = 0;
    while (!rdy && n < 40) begin tick(); n++; end
    if (!rdy) begin ok = 1'b0; return; end
    d = data;
    tick();
    ack = 1'b1;
    n = 0;
    while (rdy && n < 40) begin
      if (data !== d) ok = 1'b0;
      tick();
      n++;
    end
    if (rdy) ok = 1'b0;
    tick();
    ack = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    while (busy && n < 60) begin tick(); n++; end
    ok = !busy;
  endtask

  task automatic test_reset();
    reset = 1'b1; host_valid = 1'b0; host_data = '0; enable = 1'b0; flush = 1'b0; ack = 1'b0;
    tick(); tick();
    n_checks++;
    if ({host_ready, rdy, data, fifo_count, busy, chars_read} !== {1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_values: got ready=%b rdy=%b data=%h cnt=%0d busy=%b chars=%0d, want 1 0 0 0 0 0",
               host_ready, rdy, data, fifo_count, busy, chars_read);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_char();
    int gap;
    enable = 1'b1;
    push(5'b10011);
    tick();
    n_checks++;
    if ({rdy, fifo_count, data} !== {1'b0, 5'd0, 5'b10011}) begin
      n_fail++;
      $display("FAIL single_fetch: got rdy=%b cnt=%0d data=%b, want 0 0 10011", rdy, fifo_count, data);
    end
    tick();
    n_checks++;
    if ({rdy, busy, data} !== {1'b1, 1'b1, 5'b10011}) begin
      n_fail++;
      $display("FAIL single_rdy_latency: got rdy=%b busy=%b data=%b, want 1 1 10011", rdy, busy, data);
    end
    tick();
    ack = 1'b1;
    tick();
    n_checks++;
    if ({rdy, data} !== {1'b0, 5'b10011}) begin
      n_fail++;
      $display("FAIL single_rdy_fall: got rdy=%b data=%b, want 0 10011", rdy, data);
    end
    tick();
    ack = 1'b0;
    tick();
    n_checks++;
    if ({chars_read, busy} !== {16'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL single_chars: got chars=%0d busy=%b, want 1 1", chars_read, busy);
    end
    gap = 0;
    while (busy && gap < 50) begin gap++; tick(); end
    n_checks++;
    if (gap !== 8) begin
      n_fail++;
      $display("FAIL single_gap_len: got %0d gap cycles, want 8", gap);
    end
  endtask

  task automatic test_skip_blank();
    logic [4:0] d;
    bit ok, idle_ok;
    enable     = 1'b1;
    host_valid = 1'b1;
    host_data  = 5'b00000; tick();
    host_data  = 5'b00000; tick();
    host_data  = 5'b10101; tick();
    host_valid = 1'b0;
    io_handshake(d, ok);
    n_checks++;
    if ({ok, d} !== {1'b1, 5'b10101}) begin
      n_fail++;
      $display("FAIL skip_first_char: got ok=%b data=%b, want 1 10101", ok, d);
    end
    wait_idle(idle_ok);
    repeat (10) tick();
    n_checks++;
    if ({idle_ok, rdy, fifo_count, chars_read} !== {1'b1, 1'b0, 5'd0, 16'd2}) begin
      n_fail++;
      $display("FAIL skip_end_state: got idle=%b rdy=%b cnt=%0d chars=%0d, want 1 0 0 2",
               idle_ok, rdy, fifo_count, chars_read);
    end
  endtask

  task automatic test_full();
    logic [4:0] d;
    bit ok, idle_ok;
    enable = 1'b0;
    for (int i = 1; i <= 16; i++) push(5'(i));
    n_checks++;
    if ({fifo_count, host_ready} !== {5'd16, 1'b0}) begin
      n_fail++;
      $display("FAIL full_flag: got cnt=%0d ready=%b, want 16 0", fifo_count, host_ready);
    end
    push(5'h1F);
    n_checks++;
    if ({fifo_count, host_ready} !== {5'd16, 1'b0}) begin
      n_fail++;
      $display("FAIL full_drop17: got cnt=%0d ready=%b, want 16 0", fifo_count, host_ready);
    end
    enable = 1'b1;
    tick();
    n_checks++;
    if ({fifo_count, host_ready} !== {5'd15, 1'b1}) begin
      n_fail++;
      $display("FAIL full_first_fetch: got cnt=%0d ready=%b, want 15 1", fifo_count, host_ready);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    io_handshake(d, ok);
    wait_idle(idle_ok);
    n_checks++;
    if ({ok, idle_ok, d, fifo_count, chars_read} !== {1'b1, 1'b1, 5'd1, 5'd0, 16'd3}) begin
      n_fail++;
      $display("FAIL full_drain: got ok=%b idle=%b data=%0d cnt=%0d chars=%0d, want 1 1 1 0 3",
               ok, idle_ok, d, fifo_count, chars_read);
    end
  endtask

  task automatic test_long_ack();
    int n;
    bit bad, idle_ok;
    enable = 1'b1;
    push(5'h0A);
    n = 0;
    while (!rdy && n < 20) begin tick(); n++; end
    n_checks++;
    if ({rdy, data} !== {1'b1, 5'h0A}) begin
      n_fail++;
      $display("FAIL long_rdy: got rdy=%b data=%h, want 1 0a", rdy, data);
    end
    ack = 1'b1;
    tick();
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rdy !== 1'b0 || busy !== 1'b1 || chars_read !== 16'd3) bad = 1'b1;
      tick();
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL long_hold: got rdy/busy/chars deviation=%b (rdy=%b busy=%b chars=%0d), want 0",
               bad, rdy, busy, chars_read);
    end
    ack = 1'b0;
    tick();
    n_checks++;
    if ({chars_read, rdy} !== {16'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL long_release: got chars=%0d rdy=%b, want 4 0", chars_read, rdy);
    end
    wait_idle(idle_ok);
  endtask

  task automatic test_flush();
    logic [4:0] d;
    bit ok, idle_ok, bad;
    enable     = 1'b1;
    host_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      host_data = 5'(5'h11 + i);
      tick();
    end
    host_valid = 1'b0;
    n_checks++;
    if ({fifo_count, rdy, data} !== {5'd5, 1'b1, 5'h11}) begin
      n_fail++;
      $display("FAIL flush_setup: got cnt=%0d rdy=%b data=%h, want 5 1 11", fifo_count, rdy, data);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if ({fifo_count, rdy, data} !== {5'd0, 1'b1, 5'h11}) begin
      n_fail++;
      $display("FAIL flush_count: got cnt=%0d rdy=%b data=%h, want 0 1 11", fifo_count, rdy, data);
    end
    io_handshake(d, ok);
    wait_idle(idle_ok);
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (rdy !== 1'b0) bad = 1'b1;
      tick();
    end
    n_checks++;
    if ({ok, idle_ok, d, bad, chars_read} !== {1'b1, 1'b1, 5'h11, 1'b0, 16'd5}) begin
      n_fail++;
      $display("FAIL flush_complete: got ok=%b idle=%b data=%h extra_rdy=%b chars=%0d, want 1 1 11 0 5",
               ok, idle_ok, d, bad, chars_read);
    end
  endtask

  task automatic test_async_reset();
    int n;
    bit bad;
    enable     = 1'b1;
    host_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      host_data = 5'(5'h05 + i);
      tick();
    end
    host_valid = 1'b0;
    n = 0;
    while (!rdy && n < 20) begin tick(); n++; end
    n_checks++;
    if ({rdy, fifo_count} !== {1'b1, 5'd2}) begin
      n_fail++;
      $display("FAIL areset_setup: got rdy=%b cnt=%0d, want 1 2", rdy, fifo_count);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({rdy, busy, fifo_count, chars_read, host_ready} !== {1'b0, 1'b0, 5'd0, 16'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL areset_immediate: got rdy=%b busy=%b cnt=%0d chars=%0d ready=%b, want 0 0 0 0 1",
               rdy, busy, fifo_count, chars_read, host_ready);
    end
    tick();
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rdy !== 1'b0 || busy !== 1'b0 || fifo_count !== 5'd0) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_data_lost: got activity after reset=%b, want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single_char();
    test_skip_blank();
    test_full();
    test_long_ack();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
